// File: rtl/countdown_sequencer.sv
// Sequences N back-to-back runs of the countdown timer for one request and
// reports the total START+WAIT cycle count plus a timeout error flag.
module countdown_sequencer #(
  parameter int REP_W   = 4,
  parameter int CYC_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [REP_W-1:0] req_reps,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [CYC_W-1:0] resp_cycles,
  output logic             resp_err,
  output logic             tmr_start,
  input  logic             tmr_done,
  output logic             busy
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] LAST_WAIT = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [REP_W-1:0]  rem, rem_nxt;
  logic [CYC_W-1:0]  acc, acc_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              err, err_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
      acc   <= '0;
      wcnt  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      acc   <= acc_nxt;
      wcnt  <= wcnt_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    acc_nxt   = acc;
    wcnt_nxt  = wcnt;
    err_nxt   = err;

    if ((state == START || state == WAIT) && acc != '1)
      acc_nxt = acc + 1'b1;

    case (state)
      IDLE: begin
        if (req_valid) begin
          rem_nxt   = req_reps;
          acc_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = (req_reps == '0) ? RESP : START;
        end
      end
      START: begin
        wcnt_nxt  = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        wcnt_nxt = wcnt + 1'b1;
        // wcnt == 0 marks the first WAIT cycle, where a done left over from
        // the previous run may still be high and must not end this run.
        if (wcnt != '0 && tmr_done) begin
          rem_nxt   = rem - 1'b1;
          state_nxt = (rem == REP_W'(1)) ? RESP : START;
        end else if (wcnt == LAST_WAIT) begin
          err_nxt   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign tmr_start   = (state == START);
  assign resp_valid  = (state == RESP);
  assign resp_cycles = acc;
  assign resp_err    = err;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: a behavioural timer drives tmr_done and a
// transaction-level model predicts every handshake, pulse and response.
module tb_countdown_sequencer;

  localparam int REP_W   = 4;
  localparam int CYC_W   = 8;
  localparam int SAT_W   = 7;
  localparam int TIMEOUT = 15;
  localparam int RUN     = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [REP_W-1:0] req_reps;
  logic             resp_valid;
  logic             resp_ready;
  logic [CYC_W-1:0] resp_cycles;
  logic             resp_err;
  logic             tmr_start;
  logic             tmr_done;
  logic             busy;

  logic             satReqReady;
  logic             satRespValid;
  logic [SAT_W-1:0] satCycles;
  logic             satErr;
  logic             satTmrStart;
  logic             satBusy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  countdown_sequencer #(.REP_W(REP_W), .CYC_W(CYC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_reps(req_reps), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_cycles(resp_cycles), .resp_err(resp_err), .tmr_start(tmr_start),
    .tmr_done(tmr_done), .busy(busy)
  );

  // Narrow-accumulator copy shares all inputs so saturation is observable.
  countdown_sequencer #(.REP_W(REP_W), .CYC_W(SAT_W), .TIMEOUT(TIMEOUT)) dutSat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(satReqReady),
    .req_reps(req_reps), .resp_valid(satRespValid), .resp_ready(resp_ready),
    .resp_cycles(satCycles), .resp_err(satErr), .tmr_start(satTmrStart),
    .tmr_done(tmr_done), .busy(satBusy)
  );

  // Timer: done rises 7 edges after the start edge and stays high until the
  // next start. Mode 1 = deaf timer, mode 2 = stale done over START + first WAIT.
  int timerMode = 0;
  int tmrLeft = 0;
  bit tmrActive = 1'b0;
  int staleCnt = 0;

  assign tmr_done = (timerMode == 1) ? 1'b0 :
                    ((tmrActive && tmrLeft == 0) ||
                     (timerMode == 2 && (tmr_start || staleCnt > 0)));

  always @(posedge clk) begin
    if (tmr_start) begin
      tmrActive <= 1'b1;
      tmrLeft   <= 7;
      staleCnt  <= 1;
    end else begin
      if (tmrLeft > 0) tmrLeft <= tmrLeft - 1;
      if (staleCnt > 0) staleCnt <= staleCnt - 1;
    end
  end

  // Transaction model: latency from acceptance is 9 per run, 1+TIMEOUT on a
  // timeout, 0 for an empty request; pulses land every 9 cycles.
  bit modelOn = 1'b0;
  bit inFlight = 1'b0;
  int edgeNo = 0;
  int acceptEdge = 0;
  int expLat = 0;
  int expErr = 0;
  int expPulses = 0;

  always @(posedge clk) begin : model
    int d;
    bit hs;
    d  = edgeNo - acceptEdge;
    hs = inFlight && (d >= expLat) && resp_ready;
    edgeNo <= edgeNo + 1;
    if (rst) begin
      modelOn  <= 1'b1;
      inFlight <= 1'b0;
    end else if (modelOn && !inFlight && req_valid) begin
      inFlight   <= 1'b1;
      acceptEdge <= edgeNo + 1;
      if (timerMode == 1 && req_reps != '0) begin
        expLat    <= TIMEOUT + 1;
        expErr    <= 1;
        expPulses <= 1;
      end else begin
        expLat    <= RUN * int'(req_reps);
        expErr    <= 0;
        expPulses <= int'(req_reps);
      end
    end else if (hs) begin
      inFlight <= 1'b0;
    end
  end

  int pulseTotal = 0;
  logic [31:0] lastCycles = '0;
  logic [31:0] lastErr = '0;
  logic [31:0] lastSat = '0;

  function automatic int satur(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic compareCycle();
    int d;
    bit eValid, eStart, eBusy;
    if (!modelOn) return;
    d      = edgeNo - acceptEdge;
    eBusy  = inFlight;
    eValid = inFlight && (d >= expLat);
    eStart = inFlight && !eValid && (d % RUN == 0) && (d / RUN < expPulses);
    checkOutput("req_ready", 32'(req_ready), 32'(!eBusy));
    checkOutput("busy", 32'(busy), 32'(eBusy));
    checkOutput("tmr_start", 32'(tmr_start), 32'(eStart));
    checkOutput("resp_valid", 32'(resp_valid), 32'(eValid));
    checkOutput("sat req_ready", 32'(satReqReady), 32'(!eBusy));
    checkOutput("sat busy", 32'(satBusy), 32'(eBusy));
    checkOutput("sat tmr_start", 32'(satTmrStart), 32'(eStart));
    checkOutput("sat resp_valid", 32'(satRespValid), 32'(eValid));
    if (eValid) begin
      checkOutput("resp_cycles", 32'(resp_cycles), 32'(satur(expLat, CYC_W)));
      checkOutput("resp_err", 32'(resp_err), 32'(expErr));
      checkOutput("sat resp_cycles", 32'(satCycles), 32'(satur(expLat, SAT_W)));
      checkOutput("sat resp_err", 32'(satErr), 32'(expErr));
    end
    if (tmr_start === 1'b1) pulseTotal++;
    if (resp_valid === 1'b1) begin
      lastCycles = 32'(resp_cycles);
      lastErr    = 32'(resp_err);
      lastSat    = 32'(satCycles);
    end
  endtask

  task automatic applyStimulus(input int reps, input int mode, input int holdOff,
                               input int expC, input int expE, input int expP,
                               input string tag);
    int startPulses;
    int waited;
    timerMode   = mode;
    startPulses = pulseTotal;
    req_reps    = REP_W'(reps);
    req_valid   = 1'b1;
    resp_ready  = (holdOff == 0);
    @(negedge clk);
    req_valid = 1'b0;
    waited = 0;
    while (resp_valid !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, " resp seen"}, 32'(resp_valid), 32'd1);
    checkOutput({tag, " latency"}, 32'(waited), 32'(expC));
    if (holdOff > 0) begin
      repeat (holdOff) @(negedge clk);
      resp_ready = 1'b1;
    end
    waited = 0;
    while (resp_valid === 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    resp_ready = 1'b0;
    checkOutput({tag, " cycles"}, lastCycles, 32'(expC));
    checkOutput({tag, " err"}, lastErr, 32'(expE));
    checkOutput({tag, " pulses"}, 32'(pulseTotal - startPulses), 32'(expP));
    checkOutput({tag, " ready after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected end of run");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_reps   = '0;
    resp_ready = 1'b0;
    fork
      forever begin
        @(negedge clk);
        compareCycle();
      end
    join_none

    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset resp_cycles", 32'(resp_cycles), 32'd0);
    checkOutput("reset resp_err", 32'(resp_err), 32'd0);
    checkOutput("reset tmr_start", 32'(tmr_start), 32'd0);
    @(negedge clk);

    applyStimulus(1, 0, 0, 9, 0, 1, "reps1");
    applyStimulus(3, 0, 0, 27, 0, 3, "reps3");
    applyStimulus(0, 0, 0, 0, 0, 0, "reps0");
    applyStimulus(2, 1, 0, 16, 1, 1, "timeout");
    applyStimulus(1, 2, 0, 9, 0, 1, "stale");
    applyStimulus(2, 2, 0, 18, 0, 2, "stale2");

    // Abort a 3-run request in the WAIT phase of its second run.
    timerMode  = 0;
    req_reps   = REP_W'(3);
    req_valid  = 1'b1;
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("midrst busy before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst req_ready", 32'(req_ready), 32'd1);
    checkOutput("midrst tmr_start", 32'(tmr_start), 32'd0);
    checkOutput("midrst resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("midrst busy", 32'(busy), 32'd0);
    checkOutput("midrst resp_cycles", 32'(resp_cycles), 32'd0);
    @(negedge clk);
    applyStimulus(1, 0, 0, 9, 0, 1, "after rst");

    applyStimulus(2, 0, 5, 18, 0, 2, "backpressure");
    applyStimulus(15, 0, 0, 135, 0, 15, "reps15");
    checkOutput("reps15 sat cycles", lastSat, 32'd127);
    applyStimulus(4, 0, 2, 36, 0, 4, "reps4");

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
